// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation sequencer.
package sar_pkg;

    localparam int unsigned NBITS_MIN         = 2;
    localparam int unsigned NBITS_MAX         = 16;
    localparam int unsigned SAMPLE_CYCLES_MIN = 1;
    localparam int unsigned SAMPLE_CYCLES_MAX = 15;

    // Counter width when the sampling window is as long as it can be.
    localparam int unsigned SAMPLE_CNT_W_MAX  = $clog2(SAMPLE_CYCLES_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_HOLD,
        ST_CONV,
        ST_DONE
    } sar_state_e;

    // Keeps an out-of-range sampling window inside the supported range.
    function automatic int unsigned clamp_sample_cycles(input int unsigned n);
        if (n < SAMPLE_CYCLES_MIN) return SAMPLE_CYCLES_MIN;
        if (n > SAMPLE_CYCLES_MAX) return SAMPLE_CYCLES_MAX;
        return n;
    endfunction

    function automatic int unsigned sample_cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sar_trial_shift.sv
// One-hot bit-trial shift register: load MSB, shift toward LSB, clear.
module sar_trial_shift #(
    parameter int unsigned NBITS = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    output logic [NBITS-1:0] trial,
    output logic [NBITS-1:0] trialb,
    output logic [NBITS-1:0] trial_next_c,
    output logic             last_c
);

    localparam logic [NBITS-1:0] TRIAL_MSB = {1'b1, {(NBITS-1){1'b0}}};

    // Clear wins so an aborted or finished conversion never leaves a bit lit.
    always_comb begin
        trial_next_c = trial;
        if (clear) begin
            trial_next_c = '0;
        end else if (load) begin
            trial_next_c = TRIAL_MSB;
        end else if (shift) begin
            trial_next_c = trial >> 1;
        end
    end

    // The complement is its own register so both strobes switch on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trial  <= '0;
            trialb <= '1;
        end else begin
            trial  <= trial_next_c;
            trialb <= ~trial_next_c;
        end
    end

    assign last_c = trial[0];

endmodule

// File: rtl/sar_seq_ctrl.sv
// SAR ADC sequencer: sample/hold/bit-trial control and result capture.
module sar_seq_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned NBITS         = 6,
    parameter int unsigned SAMPLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic             comp_out,
    output logic             sample,
    output logic             comp_en,
    output logic             rs,
    output logic [NBITS-1:0] trial,
    output logic [NBITS-1:0] trialb,
    output logic [NBITS-1:0] dac_code,
    output logic [NBITS-1:0] result,
    output logic             valid,
    output logic             busy
);

    localparam int unsigned      SAMPLE_N = clamp_sample_cycles(SAMPLE_CYCLES);
    localparam int unsigned      CNT_W    = sample_cnt_width(SAMPLE_N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_N - 1);

    sar_state_e       state_q;
    sar_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [NBITS-1:0] code_q;
    logic [NBITS-1:0] code_d;
    logic [NBITS-1:0] result_d;
    logic [NBITS-1:0] trial_next_c;
    logic             trial_last_c;
    logic             trial_load;
    logic             trial_shift;
    logic             trial_clear;

    sar_trial_shift #(
        .NBITS (NBITS)
    ) u_trial_shift (
        .clk          (clk),
        .rst          (rst),
        .load         (trial_load),
        .shift        (trial_shift),
        .clear        (trial_clear),
        .trial        (trial),
        .trialb       (trialb),
        .trial_next_c (trial_next_c),
        .last_c       (trial_last_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus next values of the counter, code and result registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        code_d   = code_q;
        result_d = result;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_CONV;
                code_d  = '0;
            end
            ST_CONV: begin
                // Decision for the bit under test is taken on the edge closing its cycle.
                if (comp_out) begin
                    code_d = code_q | trial;
                end
                if (trial_last_c) begin
                    state_d  = ST_DONE;
                    result_d = code_d;
                end
            end
            ST_DONE: begin
                state_d = cont ? ST_SAMPLE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            code_d   = '0;
            result_d = result;
        end
    end

    assign trial_load  = (state_q == ST_HOLD) && (state_d == ST_CONV);
    assign trial_shift = (state_q == ST_CONV) && (state_d == ST_CONV);
    assign trial_clear = (state_d != ST_CONV);

    // Datapath and Moore outputs, registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            code_q   <= '0;
            result   <= '0;
            dac_code <= '0;
            sample   <= 1'b0;
            comp_en  <= 1'b0;
            rs       <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            result   <= result_d;
            dac_code <= code_d | trial_next_c;
            sample   <= (state_d == ST_SAMPLE);
            comp_en  <= (state_d == ST_CONV);
            rs       <= (state_d == ST_HOLD);
            valid    <= (state_d == ST_DONE);
            busy     <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Self-checking bench for sar_seq_ctrl against an ideal-converter reference model.
`timescale 1ns/1ps
module tb_sar_seq_ctrl;

    localparam int unsigned N1 = 6;
    localparam int unsigned S1 = 1;
    localparam int          P1 = S1 + N1 + 2;
    localparam int unsigned N2 = 10;
    localparam int unsigned S2 = 3;
    localparam int          P2 = S2 + N2 + 2;

    logic clk = 1'b0;
    logic rst;
    logic start, cont, abort, comp_out;
    logic sample, comp_en, rs, valid, busy;
    logic [N1-1:0] trial, trialb, dac_code, result;

    logic start2, comp_out2;
    logic sample2, comp_en2, rs2, valid2, busy2;
    logic [N2-1:0] trial2, trialb2, dac_code2, result2;

    int vin;
    int vin2;
    int comp_mode;   // 0 = behavioural comparator, 1 = stuck at 1, 2 = stuck at 0
    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    assign comp_out  = (comp_mode == 1) ? 1'b1 :
                       (comp_mode == 2) ? 1'b0 : (vin >= int'(dac_code));
    assign comp_out2 = (vin2 >= int'(dac_code2));

    sar_seq_ctrl #(.NBITS(N1), .SAMPLE_CYCLES(S1)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
        .comp_out(comp_out), .sample(sample), .comp_en(comp_en), .rs(rs),
        .trial(trial), .trialb(trialb), .dac_code(dac_code), .result(result),
        .valid(valid), .busy(busy)
    );

    sar_seq_ctrl #(.NBITS(N2), .SAMPLE_CYCLES(S2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .cont(1'b0), .abort(1'b0),
        .comp_out(comp_out2), .sample(sample2), .comp_en(comp_en2), .rs(rs2),
        .trial(trial2), .trialb(trialb2), .dac_code(dac_code2), .result(result2),
        .valid(valid2), .busy(busy2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // k-th DAC code of an ideal binary search for v under the given comparator mode.
    function automatic int model_dac(input int v, input int mode, input int k, input int nb);
        int code;
        int t;
        code = 0;
        for (int i = 0; i < k; i++) begin
            t = 1 << (nb - 1 - i);
            if (mode == 1 || (mode == 0 && v >= code + t)) code = code + t;
        end
        return code + (1 << (nb - 1 - k));
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        #12;
        n_checks++;
        if ({sample, comp_en, rs, valid, busy, trial, trialb, dac_code, result} !==
            {5'b0, 6'h00, 6'h3f, 6'h00, 6'h00}) begin
            n_fail++;
            $display("FAIL reset_values got %b %h %h %h %h want 00000 00 3f 00 00",
                     {sample, comp_en, rs, valid, busy}, trial, trialb, dac_code, result);
        end
        rst = 1'b0;
        tick;
        n_checks++;
        if (busy !== 1'b0 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle busy got %b/%b want 0/0", busy, busy2);
        end
    endtask

    task automatic test_conversion(input int v, input int mode, input string name);
        logic [4:0]    exp_ctl;
        logic [N1-1:0] exp_trial;
        logic [N1-1:0] exp_res;
        int            k;
        vin       = v;
        comp_mode = mode;
        exp_res   = (mode == 1) ? '1 : (mode == 2) ? '0 : N1'(v);
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int cyc = 1; cyc <= P1 + 1; cyc++) begin
            k         = cyc - int'(S1 + 2);
            exp_trial = (k >= 0 && k < int'(N1)) ? (N1'(1) << (int'(N1) - 1 - k)) : '0;
            exp_ctl   = {cyc <= int'(S1), cyc == int'(S1 + 1), k >= 0 && k < int'(N1),
                         cyc == P1, cyc <= P1};
            n_checks++;
            if ({sample, rs, comp_en, valid, busy} !== exp_ctl) begin
                n_fail++;
                $display("FAIL %s cyc %0d sample/rs/comp_en/valid/busy got %b want %b",
                         name, cyc, {sample, rs, comp_en, valid, busy}, exp_ctl);
            end
            n_checks++;
            if (trial !== exp_trial || trialb !== ~exp_trial) begin
                n_fail++;
                $display("FAIL %s cyc %0d trial/trialb got %h/%h want %h/%h",
                         name, cyc, trial, trialb, exp_trial, ~exp_trial);
            end
            if (k >= 0 && k < int'(N1)) begin
                n_checks++;
                if (int'(dac_code) != model_dac(v, mode, k, N1)) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d dac_code got %0d want %0d",
                             name, cyc, dac_code, model_dac(v, mode, k, N1));
                end
            end
            if (cyc >= P1) begin
                n_checks++;
                if (result !== exp_res) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d result got %0d want %0d", name, cyc, result, exp_res);
                end
            end
            tick;
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            test_conversion(int'($urandom_range(0, 63)), 0, "random");
        end
    endtask

    task automatic test_cont;
        int nvalid;
        int vcyc[2];
        int vres[2];
        nvalid    = 0;
        vcyc      = '{0, 0};
        vres      = '{0, 0};
        vin       = 10;
        comp_mode = 0;
        cont      = 1'b1;
        start     = 1'b1;
        tick;
        start = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (valid === 1'b1) begin
                if (nvalid < 2) begin
                    vcyc[nvalid] = cyc;
                    vres[nvalid] = int'(result);
                end
                nvalid++;
            end
            if (cyc == P1) vin = 50;
            if (cyc == P1 + int'(S1) + 3) cont = 1'b0;
            if (cyc == P1 + 1) begin
                n_checks++;
                if (sample !== 1'b1) begin
                    n_fail++;
                    $display("FAIL cont_no_gap sample at cyc %0d got %b want 1", cyc, sample);
                end
            end
            if (cyc == 2 * P1 + 1) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL cont_stop busy at cyc %0d got %b want 0", cyc, busy);
                end
            end
            tick;
        end
        n_checks++;
        if (nvalid != 2 || vcyc[0] != P1 || vcyc[1] != 2 * P1) begin
            n_fail++;
            $display("FAIL cont_valid count/cycles got %0d %0d %0d want 2 %0d %0d",
                     nvalid, vcyc[0], vcyc[1], P1, 2 * P1);
        end
        n_checks++;
        if (vres[0] != 10 || vres[1] != 50) begin
            n_fail++;
            $display("FAIL cont_results got %0d %0d want 10 50", vres[0], vres[1]);
        end
    endtask

    task automatic test_start_ignored;
        int v;
        int nvalid;
        int vcyc;
        v         = int'($urandom_range(0, 63));
        vin       = v;
        comp_mode = 0;
        nvalid    = 0;
        vcyc      = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            start = (cyc == 4);
            if (valid === 1'b1) begin
                nvalid++;
                vcyc = cyc;
            end
            tick;
        end
        start = 1'b0;
        n_checks++;
        if (nvalid != 1 || vcyc != P1 || int'(result) != v || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ignored valids/cyc/result/busy got %0d %0d %0d %b want 1 %0d %0d 0",
                     nvalid, vcyc, result, busy, P1, v);
        end
    endtask

    task automatic test_abort;
        int a;
        int nvalid;
        a = int'($urandom_range(0, 63));
        test_conversion(a, 0, "abort_pre");
        vin    = (a + 17) % 64;
        nvalid = 0;
        start  = 1'b1;
        tick;
        start = 1'b0;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            if (cyc == int'(S1) + 4) begin
                n_checks++;
                if (trial !== 6'b001000) begin
                    n_fail++;
                    $display("FAIL abort_bit3 trial got %b want 001000", trial);
                end
                abort = 1'b1;
            end else begin
                abort = 1'b0;
            end
            if (cyc == int'(S1) + 5) begin
                n_checks++;
                if ({busy, comp_en, sample, rs} !== 4'b0 || trial !== '0) begin
                    n_fail++;
                    $display("FAIL abort_idle busy/comp_en/sample/rs trial got %b %b want 0000 000000",
                             {busy, comp_en, sample, rs}, trial);
                end
            end
            if (valid === 1'b1) nvalid++;
            tick;
        end
        n_checks++;
        if (nvalid != 0 || int'(result) != a) begin
            n_fail++;
            $display("FAIL abort_keep valids/result got %0d %0d want 0 %0d", nvalid, result, a);
        end
        abort = 1'b1;
        start = 1'b1;
        tick;
        abort = 1'b0;
        start = 1'b0;
        tick;
        n_checks++;
        if (busy !== 1'b0 || sample !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_start busy/sample got %b/%b want 0/0", busy, sample);
        end
    endtask

    task automatic test_reset_mid;
        vin       = int'($urandom_range(1, 63));
        comp_mode = 0;
        start     = 1'b1;
        tick;
        start = 1'b0;
        for (int cyc = 1; cyc < 5; cyc++) tick;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({sample, comp_en, rs, valid, busy, trial, trialb, dac_code, result} !==
            {5'b0, 6'h00, 6'h3f, 6'h00, 6'h00}) begin
            n_fail++;
            $display("FAIL reset_mid got %b %h %h %h %h want 00000 00 3f 00 00",
                     {sample, comp_en, rs, valid, busy}, trial, trialb, dac_code, result);
        end
        #1;
        rst = 1'b0;
        tick;
        test_conversion(int'($urandom_range(0, 63)), 0, "after_rst");
    endtask

    task automatic test_nbits10(input int v);
        int nsample;
        int first_sample;
        int nrs;
        int ncomp;
        int nvalid;
        int vcyc;
        nsample      = 0;
        first_sample = 0;
        nrs          = 0;
        ncomp        = 0;
        nvalid       = 0;
        vcyc         = 0;
        vin2         = v;
        start2       = 1'b1;
        tick;
        start2 = 1'b0;
        for (int cyc = 1; cyc <= P2 + 3; cyc++) begin
            if (sample2 === 1'b1) begin
                if (nsample == 0) first_sample = cyc;
                nsample++;
            end
            if (rs2 === 1'b1) nrs++;
            if (comp_en2 === 1'b1) ncomp++;
            if (valid2 === 1'b1) begin
                nvalid++;
                vcyc = cyc;
            end
            n_checks++;
            if (trialb2 !== ~trial2) begin
                n_fail++;
                $display("FAIL nb10_trialb cyc %0d got %h want %h", cyc, trialb2, ~trial2);
            end
            tick;
        end
        n_checks++;
        if (nsample != int'(S2) || first_sample != 1 || nrs != 1 || ncomp != int'(N2)) begin
            n_fail++;
            $display("FAIL nb10_strobes sample/first/rs/comp_en got %0d %0d %0d %0d want %0d 1 1 %0d",
                     nsample, first_sample, nrs, ncomp, S2, N2);
        end
        n_checks++;
        if (nvalid != 1 || vcyc != P2 || int'(result2) != v || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL nb10_result valids/cyc/result/busy got %0d %0d %0d %b want 1 %0d %0d 0",
                     nvalid, vcyc, result2, busy2, P2, v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        start     = 1'b0;
        cont      = 1'b0;
        abort     = 1'b0;
        start2    = 1'b0;
        vin       = 0;
        vin2      = 0;
        comp_mode = 0;
        rst       = 1'b1;

        test_reset;
        test_conversion(37, 0, "ref37");
        test_conversion(0, 1, "stuck1");
        test_conversion(0, 2, "stuck0");
        test_random;
        test_cont;
        test_start_ignored;
        test_abort;
        test_reset_mid;
        test_nbits10(700);
        test_nbits10(int'($urandom_range(0, 1023)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
